// File: rtl/adc_derand_multi_pkg.sv
// Shared helpers for the LTC2208 front-end conditioner: full-scale code
// detection, saturating magnitude and the clip stretch counter width.
// The helpers work on a wide zero-extended vector plus the real sample
// width so one definition serves every DATA_WIDTH the block is built with.
package adc_derand_multi_pkg;

  localparam int MAX_W = 64;

  // Width of a counter that must be able to hold the value 'hold'.
  function automatic int cnt_width(input int hold);
    return $clog2(hold + 1);
  endfunction

  // True when the low 'w' bits of x are the max positive (0111..1) or
  // min negative (100..0) two's complement code.
  function automatic logic is_full_scale(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] max_code;
    logic [MAX_W-1:0] min_code;
    logic [MAX_W-1:0] xm;
    mask     = (64'd1 << w) - 64'd1;
    max_code = (64'd1 << (w - 1)) - 64'd1;
    min_code = 64'd1 << (w - 1);
    xm       = x & mask;
    return (xm == max_code) || (xm == min_code);
  endfunction

  // |x| of a w-bit two's complement value. The min negative code has no
  // positive counterpart in w-1 bits, so it saturates to all-ones.
  function automatic logic [MAX_W-1:0] sat_mag(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] max_code;
    logic [MAX_W-1:0] min_code;
    logic [MAX_W-1:0] xm;
    mask     = (64'd1 << w) - 64'd1;
    max_code = (64'd1 << (w - 1)) - 64'd1;
    min_code = 64'd1 << (w - 1);
    xm       = x & mask;
    if (xm == min_code) begin
      return max_code;
    end else if ((xm & min_code) != 64'd0) begin
      return (~xm + 64'd1) & mask;
    end else begin
      return xm;
    end
  endfunction

endpackage

// File: rtl/adc_derand_lane.sv
// One channel of stage 2: derandomise, clip detection with a retriggerable
// stretch counter, and the peak-magnitude hold register.
module adc_derand_lane
  import adc_derand_multi_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int HOLD_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic                  rand_en,
  input  logic                  ovr,
  input  logic                  valid,
  input  logic                  peak_clear,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  clip_flag,
  output logic [DATA_WIDTH-2:0] peak
);

  localparam int CW = cnt_width(HOLD_CYCLES);
  localparam int MW = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] derand;
  logic [MW-1:0]         mag;
  logic                  clip_event;
  logic [CW-1:0]         clip_cnt;

  // The randomiser XORs bits W-1..1 with bit 0; undo it when enabled.
  always_comb begin
    derand = x;
    if (rand_en && x[0]) begin
      derand = {~x[DATA_WIDTH-1:1], x[0]};
    end
  end

  assign mag        = MW'(sat_mag(MAX_W'(derand), DATA_WIDTH));
  assign clip_event = valid && (ovr || is_full_scale(MAX_W'(derand), DATA_WIDTH));
  assign clip_flag  = (clip_cnt != '0);

  // Output register, clip stretch counter and peak hold; the clear strobe
  // beats the old peak but never drops a sample arriving the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout     <= '0;
      clip_cnt <= '0;
      peak     <= '0;
    end else begin
      if (valid) begin
        dout <= derand;
      end
      if (clip_event) begin
        clip_cnt <= CW'(HOLD_CYCLES);
      end else if (clip_cnt != '0) begin
        clip_cnt <= clip_cnt - CW'(1);
      end
      if (peak_clear) begin
        peak <= valid ? mag : '0;
      end else if (valid && (mag > peak)) begin
        peak <= mag;
      end
    end
  end

endmodule

// File: rtl/adc_derand_multi.sv
// Multi-channel LTC2208 conditioner top: input latch, valid pipeline and
// port packing around one adc_derand_lane per channel.
module adc_derand_multi
  import adc_derand_multi_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 2,
  parameter int HOLD_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_CH-1:0]                rand_sel,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     din,
  input  logic                             din_valid,
  input  logic [NUM_CH-1:0]                ovr_in,
  output logic [NUM_CH*DATA_WIDTH-1:0]     dout,
  output logic                             dout_valid,
  output logic [NUM_CH-1:0]                clip_flag,
  output logic [NUM_CH*(DATA_WIDTH-1)-1:0] peak,
  input  logic                             peak_clear
);

  logic [NUM_CH*DATA_WIDTH-1:0] din_q;
  logic [NUM_CH-1:0]            ovr_q;
  logic [NUM_CH-1:0]            rand_q;
  logic                         valid_q;

  // Stage 1: capture everything every cycle so rand_sel travels with its sample.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      din_q   <= '0;
      ovr_q   <= '0;
      rand_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      din_q   <= din;
      ovr_q   <= ovr_in;
      rand_q  <= rand_sel;
      valid_q <= din_valid;
    end
  end

  // Stage 2 valid flag, aligned with the lane output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= valid_q;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    adc_derand_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_lane (
      .clk       (clk),
      .resetn    (resetn),
      .x         (din_q[c*DATA_WIDTH +: DATA_WIDTH]),
      .rand_en   (rand_q[c]),
      .ovr       (ovr_q[c]),
      .valid     (valid_q),
      .peak_clear(peak_clear),
      .dout      (dout[c*DATA_WIDTH +: DATA_WIDTH]),
      .clip_flag (clip_flag[c]),
      .peak      (peak[c*(DATA_WIDTH-1) +: (DATA_WIDTH-1)])
    );
  end

endmodule

// File: tb/tb_adc_derand_multi.sv
// Directed bench for adc_derand_multi with W=16, two channels, HOLD_CYCLES=8.
module tb_adc_derand_multi;

  localparam int W  = 16;
  localparam int NC = 2;
  localparam int HC = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NC-1:0]     rand_sel = '0;
  logic [NC*W-1:0]   din = '0;
  logic              din_valid = 1'b0;
  logic [NC-1:0]     ovr_in = '0;
  logic [NC*W-1:0]   dout;
  logic              dout_valid;
  logic [NC-1:0]     clip_flag;
  logic [NC*(W-1)-1:0] peak;
  logic              peak_clear = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;
  int hi;

  adc_derand_multi #(
    .DATA_WIDTH (W),
    .NUM_CH     (NC),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rand_sel  (rand_sel),
    .din       (din),
    .din_valid (din_valid),
    .ovr_in    (ovr_in),
    .dout      (dout),
    .dout_valid(dout_valid),
    .clip_flag (clip_flag),
    .peak      (peak),
    .peak_clear(peak_clear)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then let the edge capture them.
  task automatic applyStimulus(input logic v, input logic [15:0] d0, input logic [15:0] d1,
                               input logic [1:0] ovr, input logic [1:0] rsel, input logic clr);
    din_valid  = v;
    din        = {d1, d0};
    ovr_in     = ovr;
    rand_sel   = rsel;
    peak_clear = clr;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state
    resetn = 1'b0;
    tick();
    tick();
    checkOutput("rst_dout", 64'(dout), 64'h0);
    checkOutput("rst_valid", 64'(dout_valid), 64'h0);
    checkOutput("rst_clip", 64'(clip_flag), 64'h0);
    checkOutput("rst_peak", 64'(peak), 64'h0);
    resetn = 1'b1;
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);

    // Randomiser decode, per-channel enable, rand_sel travels with sample
    applyStimulus(1, 16'hFFFF, 16'h0003, 2'b00, 2'b11, 0);
    applyStimulus(1, 16'h1234, 16'h0003, 2'b00, 2'b01, 0);
    checkOutput("derand_ffff", 64'(dout[15:0]), 64'h0001);
    checkOutput("derand_ch1_on", 64'(dout[31:16]), 64'hFFFD);
    checkOutput("derand_valid", 64'(dout_valid), 64'h1);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("derand_1234", 64'(dout[15:0]), 64'h1234);
    checkOutput("derand_ch1_off", 64'(dout[31:16]), 64'h0003);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("hold_valid", 64'(dout_valid), 64'h0);
    checkOutput("hold_dout", 64'(dout), 64'h0003_1234);
    applyStimulus(1, 16'hFFFF, 16'h0003, 2'b00, 2'b00, 0);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("bypass", 64'(dout), 64'h0003_FFFF);
    applyStimulus(1, 16'h0003, 16'h0003, 2'b00, 2'b01, 0);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("indep", 64'(dout), 64'h0003_FFFD);
    checkOutput("peak_track", 64'(peak), {34'h0, 15'h0003, 15'h1234});

    // Peak magnitude and saturation
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 1);
    checkOutput("peak_clr_idle", 64'(peak), 64'h0);
    applyStimulus(1, 16'h0100, 16'h0, 2'b00, 2'b00, 0);
    applyStimulus(1, 16'hFF00, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("peak_0100", 64'(peak[14:0]), 64'h0100);
    applyStimulus(1, 16'h8000, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("peak_ff00", 64'(peak[14:0]), 64'h0100);
    applyStimulus(1, 16'h0010, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("peak_sat", 64'(peak[14:0]), 64'h7FFF);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 1);
    checkOutput("peak_clr_sample", 64'(peak[14:0]), 64'h0010);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 1);
    checkOutput("peak_clr_zero", 64'(peak), 64'h0);
    repeat (12) tick();
    checkOutput("clip_decayed", 64'(clip_flag), 64'h0);

    // Single clip event on ch1: exactly HC cycles
    applyStimulus(1, 16'h0, 16'h7FFF, 2'b00, 2'b00, 0);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    hi = int'(clip_flag[1]);
    checkOutput("clip_ch0_quiet", 64'(clip_flag[0]), 64'h0);
    for (int i = 0; i < 40 && clip_flag[1]; i++) begin
      tick();
      if (clip_flag[1]) hi++;
    end
    checkOutput("clip_len", 64'(hi), 64'(HC));
    checkOutput("clip_end", 64'(clip_flag), 64'h0);

    // Retrigger five cycles after the first event
    applyStimulus(1, 16'h0, 16'h7FFF, 2'b00, 2'b00, 0);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    hi = int'(clip_flag[1]);
    repeat (3) begin
      applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
      hi += int'(clip_flag[1]);
    end
    applyStimulus(1, 16'h0, 16'h8000, 2'b00, 2'b00, 0);
    hi += int'(clip_flag[1]);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    hi += int'(clip_flag[1]);
    for (int i = 0; i < 40 && clip_flag[1]; i++) begin
      tick();
      if (clip_flag[1]) hi++;
    end
    checkOutput("clip_retrig_len", 64'(hi), 64'(HC + 5));
    checkOutput("clip_retrig_end", 64'(clip_flag), 64'h0);

    // Overrange pin alone
    applyStimulus(1, 16'h0, 16'h0, 2'b10, 2'b00, 0);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("clip_ovr", 64'(clip_flag), 64'h2);
    repeat (12) tick();

    // Valid gaps: invalid full-scale/overrange sample must not count
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 1);
    applyStimulus(1, 16'h0005, 16'h0, 2'b00, 2'b00, 0);
    applyStimulus(0, 16'h7FFF, 16'h0, 2'b01, 2'b00, 0);
    checkOutput("gap_v1", 64'(dout_valid), 64'h1);
    checkOutput("gap_d1", 64'(dout[15:0]), 64'h0005);
    applyStimulus(1, 16'h0007, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("gap_v0", 64'(dout_valid), 64'h0);
    checkOutput("gap_hold", 64'(dout[15:0]), 64'h0005);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("gap_v2", 64'(dout_valid), 64'h1);
    checkOutput("gap_d2", 64'(dout[15:0]), 64'h0007);
    checkOutput("gap_peak", 64'(peak[14:0]), 64'h0007);
    checkOutput("gap_clip", 64'(clip_flag), 64'h0);

    // Reset during a clip stretch with samples in flight
    applyStimulus(1, 16'h0, 16'h7FFF, 2'b00, 2'b00, 0);
    applyStimulus(1, 16'h1111, 16'h2222, 2'b00, 2'b00, 0);
    checkOutput("pre_rst_clip", 64'(clip_flag), 64'h2);
    din_valid = 1'b1;
    din       = 32'h4444_3333;
    resetn    = 1'b0;
    tick();
    checkOutput("midrst_dout", 64'(dout), 64'h0);
    checkOutput("midrst_valid", 64'(dout_valid), 64'h0);
    checkOutput("midrst_clip", 64'(clip_flag), 64'h0);
    checkOutput("midrst_peak", 64'(peak), 64'h0);
    resetn = 1'b1;
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("post_rst_valid1", 64'(dout_valid), 64'h0);
    checkOutput("post_rst_dout1", 64'(dout), 64'h0);
    applyStimulus(0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
    checkOutput("post_rst_valid2", 64'(dout_valid), 64'h0);
    checkOutput("post_rst_dout2", 64'(dout), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
